// File: rtl/uart_tx_1007_if.sv
// Byte intake handshake between the producing user logic and the UART transmitter.
interface uart_tx_1007_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_1007.sv
// Byte-wide 8N1 UART transmitter: valid/ready byte intake, LSB-first serial out.
// tx, busy and tx_ready are all registered so the pin never glitches.
module uart_tx_1007 #(
    parameter int unsigned CLK_DIV   = 868,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_1007_if.slave s,
    output logic          tx,
    output logic          busy
);
    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    if (CLK_DIV < 2 || CLK_DIV > 65535 || DATA_BITS < 5 || DATA_BITS > 8) begin : g_param_check
        $error("uart_tx_1007: CLK_DIV or DATA_BITS out of range");
    end

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 ready_q, ready_d;
    logic                 bit_end;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        bit_end = (baud_q == BAUD_LAST);

        case (state_q)
            IDLE: begin
                if (s.tx_valid && ready_q) begin
                    state_d = START;
                    shift_d = s.tx_data;
                    baud_d  = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                        bit_d   = '0;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are derived from the next state so the registered pin lines up with the state.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign s.tx_ready = ready_q;
endmodule

// File: tb/tb_uart_tx_1007.sv
// Bench for uart_tx_1007: three parameter corners checked cycle-by-cycle against a frame model.
module tb_uart_tx_1007;
    logic clk;
    logic reset;

    int cd_a [3] = '{4, 2, 868};
    int db_a [3] = '{8, 5, 8};

    logic [7:0] data_r  [3];
    logic       valid_r [3];
    logic       tx_w    [3];
    logic       busy_w  [3];
    logic       ready_w [3];

    int vec_cnt = 0;
    int err_cnt = 0;

    uart_tx_1007_if #(.DATA_BITS(8)) if0 ();
    uart_tx_1007_if #(.DATA_BITS(5)) if1 ();
    uart_tx_1007_if #(.DATA_BITS(8)) if2 ();

    assign if0.tx_data  = data_r[0];
    assign if1.tx_data  = data_r[1][4:0];
    assign if2.tx_data  = data_r[2];
    assign if0.tx_valid = valid_r[0];
    assign if1.tx_valid = valid_r[1];
    assign if2.tx_valid = valid_r[2];
    assign ready_w[0]   = if0.tx_ready;
    assign ready_w[1]   = if1.tx_ready;
    assign ready_w[2]   = if2.tx_ready;

    uart_tx_1007 #(.CLK_DIV(4), .DATA_BITS(8)) u_dut0 (
        .clk(clk), .reset(reset), .s(if0), .tx(tx_w[0]), .busy(busy_w[0]));
    uart_tx_1007 #(.CLK_DIV(2), .DATA_BITS(5)) u_dut1 (
        .clk(clk), .reset(reset), .s(if1), .tx(tx_w[1]), .busy(busy_w[1]));
    uart_tx_1007 #(.CLK_DIV(868), .DATA_BITS(8)) u_dut2 (
        .clk(clk), .reset(reset), .s(if2), .tx(tx_w[2]), .busy(busy_w[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_idle(input int idx, input string tag);
        chk_eq({tag, "_tx"}, 32'(tx_w[idx]), 32'd1);
        chk_eq({tag, "_busy"}, 32'(busy_w[idx]), 32'd0);
        chk_eq({tag, "_ready"}, 32'(ready_w[idx]), 32'd1);
    endtask

    // Called at a negedge. mode 0: plain; 1: tx_data churns and tx_valid pulses (0x3C) mid-frame;
    // 2: tx_valid stays high with nxt already on tx_data for a back-to-back frame.
    task automatic send(input int idx, input logic [7:0] b, input int mode, input logic [7:0] nxt);
        int cd, db, flen, n, k;
        logic [7:0] rx, m, exp_bit;
        cd   = cd_a[idx];
        db   = db_a[idx];
        flen = (db + 2) * cd;
        m    = 8'((1 << db) - 1);
        rx   = '0;
        n    = 0;
        while (!ready_w[idx] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk_eq("ready_wait", 32'(ready_w[idx]), 32'd1);
        data_r[idx]  = b;
        valid_r[idx] = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= flen; c++) begin
            @(negedge clk);
            case (mode)
                1: begin
                    data_r[idx]  = 8'($urandom);
                    valid_r[idx] = (c < flen - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                    if (valid_r[idx]) data_r[idx] = 8'h3C;
                end
                2: data_r[idx] = nxt;
                default: valid_r[idx] = 1'b0;
            endcase
            k = (c - 1) / cd;
            if (k == 0)       exp_bit = 8'd0;
            else if (k <= db) exp_bit = 8'(b[k-1]);
            else              exp_bit = 8'd1;
            chk_eq("tx_bit", 32'(tx_w[idx]), 32'(exp_bit));
            chk_eq("busy_frame", 32'(busy_w[idx]), 32'd1);
            chk_eq("ready_frame", 32'(ready_w[idx]), 32'd0);
            if (k >= 1 && k <= db && ((c - 1) % cd) == cd / 2) rx[k-1] = tx_w[idx];
        end
        @(negedge clk);
        chk_idle(idx, "post_frame");
        chk_eq("rx_byte", 32'(rx), 32'(b & m));
    endtask

    initial begin
        logic [7:0] r;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_r[i]  = '0;
            valid_r[i] = 1'b0;
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) chk_idle(i, "reset");
        end
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) chk_idle(i, "idle");
        end

        send(0, 8'hA5, 0, 8'h00);
        send(0, 8'($urandom), 1, 8'h00);
        send(0, 8'h00, 2, 8'hFF);
        send(0, 8'hFF, 0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            r = 8'($urandom);
            send(0, r, int'($urandom_range(0, 1)), 8'h00);
        end
        @(negedge clk);
        chk_idle(0, "no_extra_frame");

        // Abandon a frame during data bit 3 of 0xA5 (cycle 17 after the handshake).
        data_r[0]  = 8'hA5;
        valid_r[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_r[0] = 1'b0;
        repeat (16) @(negedge clk);
        chk_eq("bit3_before_reset", 32'(tx_w[0]), 32'd0);
        reset = 1'b0;
        #1;
        chk_idle(0, "reset_async");
        repeat (3) begin
            @(negedge clk);
            chk_idle(0, "reset_hold");
        end
        reset = 1'b1;
        repeat (22) begin
            @(negedge clk);
            chk_idle(0, "after_reset");
        end

        send(1, 8'h15, 0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            r = 8'($urandom);
            send(1, r, 0, 8'h00);
        end

        send(2, 8'hC3, 0, 8'h00);
        r = 8'($urandom);
        send(2, r, 0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/uart_tx_1007.md
Name: uart_tx_1007

Overview:
- Byte-wide UART transmitter (8N1) for the Mimas V2 board.
- Accepts a byte over a valid/ready handshake, serialises it LSB-first with one start bit and one stop bit, and drives the board's serial TX pin.
- Sits between the byte-producing user logic and the USB-UART bridge.
- Its outputs are all registered so the pin is glitch-free.

Parameters:
- CLK_DIV, 868, clock cycles per bit (100 MHz / 115200 baud); legal range 2..65535.
- DATA_BITS, 8, payload bits per frame; legal range 5..8.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately, release synchronous to clk.
- tx_data  input  DATA_BITS  byte to send, sampled only at handshake.
- tx_valid  input  1  producer has a byte on tx_data.
- tx_ready  output  1  block can accept a byte this cycle.
- tx  output  1  serial line, idle high.
- busy  output  1  frame in progress (start, data or stop bit on the line).

Behaviour:
- Reset values (reset=0, asynchronous):
  - tx=1, tx_ready=1, busy=0.
  - State IDLE, bit counter 0, baud counter 0, shift register 0.
- States: IDLE, START, DATA, STOP.
- Handshake:
  - Transfer occurs on a rising edge where tx_valid=1 and tx_ready=1.
  - tx_data is latched into the shift register at that edge.
  - tx_ready=1 only in IDLE.
  - tx_data/tx_valid are ignored outside IDLE; no buffering, no dropped-byte flag.
- IDLE:
  - tx=1, busy=0.
  - On transfer, go to START: next cycle tx=0, busy=1, tx_ready=0, baud counter cleared.
- Baud counter:
  - Counts 0..CLK_DIV-1 in each bit state.
  - Terminal count ends the current bit; counter width is ceil(log2(CLK_DIV)).
- START: tx=0 for exactly CLK_DIV cycles, then go to DATA.
- DATA:
  - tx = shift-register bit 0; each bit is held CLK_DIV cycles.
  - At the end of each bit, shift right and increment the bit counter.
  - After DATA_BITS bits, go to STOP.
- STOP:
  - tx=1 for exactly CLK_DIV cycles, then go to IDLE.
  - tx_ready=1 and busy=0 on the cycle after the last stop cycle.
- Timing:
  - Handshake-to-start-bit latency: 1 cycle.
  - Frame length: (DATA_BITS+2)*CLK_DIV cycles.
  - Back-to-back transfers (tx_valid held high) give a 1-cycle idle-high gap between stop bit and next start bit.
- tx changes only on bit boundaries (registered); no glitches inside a bit.
- Reset mid-frame:
  - tx returns to 1 asynchronously; the frame is abandoned.
  - After release the block is in IDLE with tx_ready=1.
  - No partial frame resumes.
- tx_valid deasserted before acceptance: no transfer; tx stays 1.
- tx_data changing mid-frame has no effect on the line.
- Out-of-range parameters are unsupported; elaboration-time check recommended.

Test Plan:
- Reset mid-frame: CLK_DIV=4, DATA_BITS=8. Assert reset low for 3 cycles during idle -> tx=1, tx_ready=1, busy=0 throughout. Then send 0xA5, pull reset low during bit 3 -> tx=1 within the same cycle; after release, tx_ready=1 and tx stays 1 for 20+ cycles.
- Single byte 0xA5, CLK_DIV=4:
  - tx=0 for cycles 1-4 after the handshake.
  - Then bits 1,0,1,0,0,1,0,1, each 4 cycles.
  - Then tx=1 for 4 cycles.
  - tx_ready returns to 1 at cycle 41; busy high for cycles 1-40.
- Back-to-back 0x00 then 0xFF with tx_valid held high:
  - Second handshake on the cycle tx_ready rises.
  - Exactly 1 idle-high cycle between frames.
  - A UART bench receiver decodes 0x00 then 0xFF.
- Handshake gating and data stability: pulse tx_valid with tx_data=0x3C while busy=1 -> no extra frame, line unaffected. Toggle tx_data every cycle mid-frame -> transmitted byte equals the value latched at the handshake.
- Parameter corners:
  - CLK_DIV=2, DATA_BITS=5, byte 0x15: frame is 14 cycles, bits 1,0,1,0,1.
  - CLK_DIV=868: frame is 8680 cycles and decodes correctly at 115200 baud.
